// File: rtl/soundglu_pkg.sv
// Shared constants and the command record for the buffered Sound GLU.
package soundglu_pkg;
   localparam int SG_ADDR_W = 16;
   localparam int SG_DATA_W = 8;

   localparam logic [1:0] SNDCTL  = 2'd0;
   localparam logic [1:0] SNDDATA = 2'd1;
   localparam logic [1:0] SNDAPL  = 2'd2;
   localparam logic [1:0] SNDAPH  = 2'd3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam int CTL_BUSY = 7;
   localparam int CTL_RAM  = 6;
   localparam int CTL_AINC = 5;
   localparam int CTL_OVF  = 4;

   typedef struct packed {
      logic                 is_wr;
      logic                 tgt;
      logic [SG_ADDR_W-1:0] addr;
      logic [SG_DATA_W-1:0] data;
   } cmd_t;
endpackage

// File: rtl/soundglu_cmd_fifo.sv
// Synchronous command FIFO; push and pop may happen on the same edge.
module soundglu_cmd_fifo
   import soundglu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  cmd_t push_cmd,
   input  logic pop,
   output logic full,
   output logic empty,
   output cmd_t head
);
   localparam int PTR_W = $clog2(DEPTH);

   cmd_t             mem_q [DEPTH];
   cmd_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_cmd;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: rtl/soundglu_buffered.sv
// Buffered Sound GLU: host register bridge posting SNDDATA accesses into a FIFO retired one per DOC slot.
//  state     | meaning
//  ST_IDLE   | waiting for a DOC slot with a queued command
//  ST_ISSUE  | command on the bus, write strobe high for this cycle
//  ST_FINISH | read data valid; capture it and retire the head entry
module soundglu_buffered
   import soundglu_pkg::*;
#(
   parameter int ADDR_W     = SG_ADDR_W,
   parameter int DATA_W     = SG_DATA_W,
   parameter int SLOT_DIV   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              select,
   input  logic              wr,
   input  logic [1:0]        host_addr,
   input  logic [DATA_W-1:0] host_data_in,
   output logic [DATA_W-1:0] host_data_out,
   input  logic [DATA_W-1:0] sound_data_in,
   output logic [ADDR_W-1:0] sound_addr,
   output logic [DATA_W-1:0] sound_data_out,
   output logic              ram_access,
   output logic              ram_wr,
   output logic              doc_wr,
   output logic              doc_enable
);
   localparam int CNT_W = $clog2(SLOT_DIV);

   logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
   logic              doc_enable_q, doc_enable_d;
   logic              select_q, select_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ram_sel_q, ram_sel_d;
   logic              auto_inc_q, auto_inc_d;
   logic [3:0]        volume_q, volume_d;
   logic              overflow_q, overflow_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic [DATA_W-1:0] host_data_out_q, host_data_out_d;
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] sound_addr_q, sound_addr_d;
   logic [DATA_W-1:0] sound_data_out_q, sound_data_out_d;
   logic              ram_access_q, ram_access_d;
   logic              ram_wr_q, ram_wr_d;
   logic              doc_wr_q, doc_wr_d;

   logic              access;
   logic              busy;
   logic [7:0]        ctl_rd;
   logic              push, pop, full, empty;
   cmd_t              push_cmd, head;

   soundglu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .push_cmd (push_cmd),
      .pop      (pop),
      .full     (full),
      .empty    (empty),
      .head     (head)
   );

   assign access = select & ~select_q;
   assign busy   = ~empty | (state_q != ST_IDLE);

   always_comb begin
      slot_cnt_d   = (slot_cnt_q == CNT_W'(SLOT_DIV-1)) ? '0 : slot_cnt_q + 1'b1;
      doc_enable_d = (slot_cnt_q == '0);
      select_d     = select;
      ctl_rd           = '0;
      ctl_rd[CTL_BUSY] = busy;
      ctl_rd[CTL_RAM]  = ram_sel_q;
      ctl_rd[CTL_AINC] = auto_inc_q;
      ctl_rd[CTL_OVF]  = overflow_q;
      ctl_rd[3:0]      = volume_q;
   end

   // Host side: exactly one register action per select rising edge.
   always_comb begin
      ptr_d           = ptr_q;
      ram_sel_d       = ram_sel_q;
      auto_inc_d      = auto_inc_q;
      volume_d        = volume_q;
      overflow_d      = overflow_q;
      host_data_out_d = host_data_out_q;
      push            = 1'b0;
      push_cmd        = '0;
      if (access) begin
         case (host_addr)
            SNDCTL: begin
               if (wr) begin
                  ram_sel_d  = host_data_in[CTL_RAM];
                  auto_inc_d = host_data_in[CTL_AINC];
                  volume_d   = host_data_in[3:0];
                  overflow_d = 1'b0;
               end else begin
                  host_data_out_d = ctl_rd;
               end
            end
            SNDDATA: begin
               if (!wr) begin
                  host_data_out_d = read_data_q;
               end
               if (full) begin
                  overflow_d = 1'b1;
               end else begin
                  push           = 1'b1;
                  push_cmd.is_wr = wr;
                  push_cmd.tgt   = ram_sel_q;
                  push_cmd.addr  = ptr_q;
                  push_cmd.data  = wr ? host_data_in : '0;
                  if (auto_inc_q) begin
                     ptr_d = ptr_q + 1'b1;
                  end
               end
            end
            SNDAPL: begin
               if (wr) begin
                  ptr_d[7:0] = host_data_in;
               end else begin
                  host_data_out_d = ptr_q[7:0];
               end
            end
            default: begin
               if (wr) begin
                  ptr_d[ADDR_W-1:8] = host_data_in[ADDR_W-9:0];
               end else begin
                  host_data_out_d = DATA_W'(ptr_q[ADDR_W-1:8]);
               end
            end
         endcase
      end
   end

   // Bus side: one command per slot, bus fields hold between commands.
   always_comb begin
      state_d          = state_q;
      sound_addr_d     = sound_addr_q;
      sound_data_out_d = sound_data_out_q;
      ram_access_d     = ram_access_q;
      ram_wr_d         = 1'b0;
      doc_wr_d         = 1'b0;
      read_data_d      = read_data_q;
      pop              = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (doc_enable_q && !empty) begin
               state_d          = ST_ISSUE;
               sound_addr_d     = head.addr;
               sound_data_out_d = head.data;
               ram_access_d     = head.tgt;
               doc_wr_d         = head.is_wr & ~head.tgt;
               ram_wr_d         = head.is_wr & head.tgt;
            end
         end
         ST_ISSUE: begin
            state_d = ST_FINISH;
         end
         ST_FINISH: begin
            if (!head.is_wr) begin
               read_data_d = sound_data_in;
            end
            pop     = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         slot_cnt_q       <= '0;
         doc_enable_q     <= 1'b0;
         select_q         <= 1'b0;
         ptr_q            <= '0;
         ram_sel_q        <= 1'b0;
         auto_inc_q       <= 1'b0;
         volume_q         <= '0;
         overflow_q       <= 1'b0;
         read_data_q      <= '0;
         host_data_out_q  <= '0;
         state_q          <= ST_IDLE;
         sound_addr_q     <= '0;
         sound_data_out_q <= '0;
         ram_access_q     <= 1'b0;
         ram_wr_q         <= 1'b0;
         doc_wr_q         <= 1'b0;
      end else begin
         slot_cnt_q       <= slot_cnt_d;
         doc_enable_q     <= doc_enable_d;
         select_q         <= select_d;
         ptr_q            <= ptr_d;
         ram_sel_q        <= ram_sel_d;
         auto_inc_q       <= auto_inc_d;
         volume_q         <= volume_d;
         overflow_q       <= overflow_d;
         read_data_q      <= read_data_d;
         host_data_out_q  <= host_data_out_d;
         state_q          <= state_d;
         sound_addr_q     <= sound_addr_d;
         sound_data_out_q <= sound_data_out_d;
         ram_access_q     <= ram_access_d;
         ram_wr_q         <= ram_wr_d;
         doc_wr_q         <= doc_wr_d;
      end
   end

   assign host_data_out  = host_data_out_q;
   assign sound_addr     = sound_addr_q;
   assign sound_data_out = sound_data_out_q;
   assign ram_access     = ram_access_q;
   assign ram_wr         = ram_wr_q;
   assign doc_wr         = doc_wr_q;
   assign doc_enable     = doc_enable_q;
endmodule

// File: tb/tb_soundglu_buffered.sv
// Bench for soundglu_buffered: directed scenarios plus random host traffic against a queue-based model.
module tb_soundglu_buffered;
   localparam int SLOT_DIV = 32;
   localparam int DEPTH    = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        select, wr;
   logic [1:0]  host_addr;
   logic [7:0]  host_data_in, host_data_out, sound_data_in, sound_data_out;
   logic [15:0] sound_addr;
   logic        ram_access, ram_wr, doc_wr, doc_enable;

   always #5 clk = ~clk;

   soundglu_buffered #(.ADDR_W(16), .DATA_W(8), .SLOT_DIV(SLOT_DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .select(select), .wr(wr), .host_addr(host_addr),
      .host_data_in(host_data_in), .host_data_out(host_data_out), .sound_data_in(sound_data_in),
      .sound_addr(sound_addr), .sound_data_out(sound_data_out), .ram_access(ram_access),
      .ram_wr(ram_wr), .doc_wr(doc_wr), .doc_enable(doc_enable)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] init_val(input logic tgt, input logic [15:0] a);
      if (tgt) return a[7:0] ^ a[15:8] ^ 8'h33;
      if (a[7:0] == 8'hE1) return 8'h3F;
      return a[7:0] ^ 8'hA5;
   endfunction

   // bus slave memories
   logic [7:0] doc_mem [logic [7:0]];
   logic [7:0] ram_mem [logic [15:0]];
   // model memories
   logic [7:0] m_doc [logic [7:0]];
   logic [7:0] m_ram [logic [15:0]];

   function automatic logic [7:0] slv_rd(input logic tgt, input logic [15:0] a);
      if (tgt) return ram_mem.exists(a) ? ram_mem[a] : init_val(1'b1, a);
      return doc_mem.exists(a[7:0]) ? doc_mem[a[7:0]] : init_val(1'b0, a);
   endfunction

   function automatic logic [7:0] mdl_rd(input logic tgt, input logic [15:0] a);
      if (tgt) return m_ram.exists(a) ? m_ram[a] : init_val(1'b1, a);
      return m_doc.exists(a[7:0]) ? m_doc[a[7:0]] : init_val(1'b0, a);
   endfunction

   typedef struct packed {
      logic        is_wr;
      logic        tgt;
      logic [15:0] addr;
      logic [7:0]  data;
   } mcmd_t;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        racc;
      logic        rwr;
   } obs_t;

   obs_t  obs[$];
   mcmd_t mq[$];

   logic [15:0] m_ptr, m_saddr;
   logic        m_ram_sel, m_ainc, m_ovf, m_racc, m_rwr, m_dwr, m_den, m_sel_prev;
   logic [3:0]  m_vol;
   logic [7:0]  m_rd, m_hdo, m_sdo;
   int          m_cnt, m_left;

   // Model: commands wait in a queue, start on a slot pulse, retire two clocks later.
   task automatic model_step();
      int         sz0;
      logic       den0, acc;
      logic [7:0] rd0;
      mcmd_t      c;
      if (!reset_n) begin
         m_ptr = '0; m_ram_sel = 0; m_ainc = 0; m_ovf = 0; m_vol = '0; m_rd = '0; m_hdo = '0;
         m_saddr = '0; m_sdo = '0; m_racc = 0; m_rwr = 0; m_dwr = 0; m_den = 0; m_sel_prev = 0;
         m_cnt = 0; m_left = 0;
         mq.delete();
         return;
      end
      sz0 = mq.size();
      den0 = m_den;
      rd0 = m_rd;
      acc = select && !m_sel_prev;
      m_sel_prev = select;
      m_rwr = 0;
      m_dwr = 0;
      if (acc) begin
         case (host_addr)
            2'd0: if (wr) begin
                     m_ram_sel = host_data_in[6]; m_ainc = host_data_in[5];
                     m_vol = host_data_in[3:0]; m_ovf = 0;
                  end else m_hdo = {sz0 != 0, m_ram_sel, m_ainc, m_ovf, m_vol};
            2'd1: begin
               if (!wr) m_hdo = rd0;
               if (sz0 >= DEPTH) m_ovf = 1;
               else begin
                  mq.push_back('{wr, m_ram_sel, m_ptr, wr ? host_data_in : 8'h00});
                  if (m_ainc) m_ptr = m_ptr + 16'd1;
               end
            end
            2'd2: if (wr) m_ptr[7:0] = host_data_in; else m_hdo = m_ptr[7:0];
            default: if (wr) m_ptr[15:8] = host_data_in; else m_hdo = m_ptr[15:8];
         endcase
      end
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            c = mq.pop_front();
            if (!c.is_wr) m_rd = mdl_rd(c.tgt, c.addr);
         end
      end else if (den0 && sz0 > 0) begin
         c = mq[0];
         m_saddr = c.addr; m_sdo = c.data; m_racc = c.tgt;
         m_dwr = c.is_wr & !c.tgt;
         m_rwr = c.is_wr & c.tgt;
         if (c.is_wr) begin
            if (c.tgt) m_ram[c.addr] = c.data; else m_doc[c.addr[7:0]] = c.data;
         end
         m_left = 2;
      end
      m_den = (m_cnt == 0);
      m_cnt = (m_cnt + 1) % SLOT_DIV;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("outs",
            64'({host_data_out, sound_addr, sound_data_out, ram_access, ram_wr, doc_wr, doc_enable}),
            64'({m_hdo, m_saddr, m_sdo, m_racc, m_rwr, m_dwr, m_den}));
      if (doc_wr) doc_mem[sound_addr[7:0]] = sound_data_out;
      if (ram_wr) ram_mem[sound_addr] = sound_data_out;
      if (ram_wr || doc_wr) obs.push_back('{cyc, sound_addr, sound_data_out, ram_access, ram_wr});
      sound_data_in = slv_rd(ram_access, sound_addr);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
      select = 1; wr = 1; host_addr = a; host_data_in = d;
      tick();
      select = 0;
      tick();
   endtask

   task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
      select = 1; wr = 0; host_addr = a; host_data_in = $urandom;
      tick();
      d = host_data_out;
      select = 0;
      tick();
   endtask

   task automatic wait_doc_enable();
      logic seen = 0;
      for (int i = 0; i < SLOT_DIV + 2 && !seen; i++) begin
         tick();
         seen = doc_enable;
      end
      if (!seen) check("doc_enable_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      logic [7:0] rd;
      int         base;
      reset_n = 0; select = 0; wr = 0; host_addr = 0; host_data_in = 0; sound_data_in = 0;
      ticks(3);
      check("reset_outs", 64'({host_data_out, sound_addr, sound_data_out, ram_access, ram_wr, doc_wr, doc_enable}), 64'(0));
      reset_n = 1;
      tick();
      check("first_doc_enable", 64'(doc_enable), 64'(1));
      host_rd(2'd0, rd);
      check("ctl_after_reset", 64'(rd), 64'(8'h00));

      // burst of four RAM writes
      host_wr(2'd0, 8'h60);
      host_wr(2'd2, 8'h00);
      host_wr(2'd3, 8'h10);
      base = obs.size();
      host_wr(2'd1, 8'hAA); host_wr(2'd1, 8'hBB); host_wr(2'd1, 8'hCC); host_wr(2'd1, 8'hDD);
      ticks(5 * SLOT_DIV);
      check("burst_count", 64'(obs.size() - base), 64'(4));
      for (int i = 0; i < 4; i++) begin
         if (base + i < obs.size()) begin
            check("burst_addr", 64'(obs[base+i].addr), 64'(16'h1000 + i));
            check("burst_data", 64'(obs[base+i].data), 64'(8'hAA + 8'(i * 17)));
            check("burst_ram", 64'({obs[base+i].racc, obs[base+i].rwr}), 64'(2'b11));
            if (i > 0) check("burst_slot_gap", 64'(obs[base+i].cyc - obs[base+i-1].cyc), 64'(SLOT_DIV));
         end
      end
      host_rd(2'd0, rd);
      check("burst_busy_clear", 64'(rd), 64'(8'h60));

      // overflow: five writes inside one slot
      host_wr(2'd2, 8'h00);
      host_wr(2'd3, 8'h20);
      wait_doc_enable();
      for (int i = 0; i < 5; i++) host_wr(2'd1, 8'(8'h50 + i));
      host_rd(2'd0, rd);
      check("ovf_ctl", 64'(rd), 64'(8'hF0));
      host_rd(2'd2, rd);
      check("ovf_ptr_lo", 64'(rd), 64'(8'h04));
      host_rd(2'd3, rd);
      check("ovf_ptr_hi", 64'(rd), 64'(8'h20));
      host_wr(2'd0, 8'h60);
      host_rd(2'd0, rd);
      check("ovf_cleared", 64'(rd[4]), 64'(0));
      ticks(5 * SLOT_DIV);

      // read prefetch from DOC register E1
      host_wr(2'd0, 8'h20);
      host_wr(2'd3, 8'h00);
      host_wr(2'd2, 8'hE1);
      host_rd(2'd1, rd);
      check("prefetch_stale", 64'(rd), 64'(8'h00));
      ticks(2 * SLOT_DIV);
      host_rd(2'd1, rd);
      check("prefetch_value", 64'(rd), 64'(8'h3F));
      host_rd(2'd2, rd);
      check("prefetch_ptr", 64'(rd), 64'(8'hE3));
      ticks(2 * SLOT_DIV);

      // ordering: read queued behind a write to the same DOC register
      host_wr(2'd0, 8'h00);
      host_wr(2'd2, 8'h40);
      base = obs.size();
      host_wr(2'd1, 8'h12);
      host_rd(2'd1, rd);
      ticks(3 * SLOT_DIV);
      check("order_doc_wr", 64'({obs.size() - base == 1, obs[obs.size()-1].addr, obs[obs.size()-1].racc}), 64'({1'b1, 16'h0040, 1'b0}));
      host_rd(2'd1, rd);
      check("order_capture", 64'(rd), 64'(8'h12));
      ticks(2 * SLOT_DIV);

      // pointer wrap and target latching
      host_wr(2'd0, 8'h60);
      host_wr(2'd3, 8'hFF);
      host_wr(2'd2, 8'hFF);
      base = obs.size();
      host_wr(2'd1, 8'h11);
      host_wr(2'd1, 8'h22);
      host_wr(2'd0, 8'h20);
      ticks(3 * SLOT_DIV);
      check("wrap_count", 64'(obs.size() - base), 64'(2));
      if (obs.size() - base == 2) begin
         check("wrap_first", 64'({obs[base].addr, obs[base].racc, obs[base].rwr}), 64'({16'hFFFF, 2'b11}));
         check("wrap_second", 64'({obs[base+1].addr, obs[base+1].racc, obs[base+1].rwr}), 64'({16'h0000, 2'b11}));
      end
      host_rd(2'd2, rd);
      check("wrap_ptr_lo", 64'(rd), 64'(8'h01));
      host_rd(2'd3, rd);
      check("wrap_ptr_hi", 64'(rd), 64'(8'h00));

      // reset while a command is on the bus
      host_wr(2'd0, 8'h60);
      host_wr(2'd1, 8'h77);
      host_wr(2'd1, 8'h78);
      begin
         logic seen = 0;
         for (int i = 0; i < 2 * SLOT_DIV && !seen; i++) begin
            tick();
            seen = ram_wr;
         end
         check("issue_seen", 64'(seen), 64'(1));
      end
      reset_n = 0;
      tick();
      check("midreset_outs", 64'({host_data_out, sound_addr, sound_data_out, ram_access, ram_wr, doc_wr, doc_enable}), 64'(0));
      reset_n = 1;
      base = obs.size();
      ticks(3 * SLOT_DIV);
      check("midreset_no_strobe", 64'(obs.size() - base), 64'(0));
      host_rd(2'd0, rd);
      check("midreset_ctl", 64'(rd), 64'(8'h00));

      // random host traffic
      for (int n = 0; n < 300; n++) begin
         logic [1:0] a;
         a = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) host_wr(a, 8'($urandom));
         else host_rd(a, rd);
         ticks($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) ticks(SLOT_DIV);
      end
      ticks(6 * SLOT_DIV);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
